// File: rtl/kbd_pkg.sv
// Shared constants, FSM state and event record for the keyboard event decoder.
package kbd_pkg;

  localparam logic [7:0] PFX_E0     = 8'hE0;
  localparam logic [7:0] PFX_F0     = 8'hF0;
  localparam logic [7:0] PFX_E1     = 8'hE1;
  localparam logic [7:0] PAUSE_CODE = 8'h77;
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  typedef enum logic [2:0] {
    StIdle,
    StE0,
    StF0,
    StE0F0,
    StPause
  } state_e;

  typedef struct packed {
    logic       rpt;
    logic       brk;
    logic       ext;
    logic [7:0] code;
  } kbd_evt_t;

  localparam int unsigned EVT_W = $bits(kbd_evt_t);

endpackage

// File: rtl/kbd_evt_fifo.sv
// First-word-fall-through FIFO of packed key events with occupancy output.
module kbd_evt_fifo
  import kbd_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [EVT_W-1:0] wdata_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [EVT_W-1:0] rdata_o,
  output logic [AW:0]      level_o
);

  logic [EVT_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      level_q;
  logic             do_push, do_pop;

  assign valid_o = (level_q != '0);
  assign do_pop  = valid_o & ready_i;
  assign do_push = push_i & (level_q != (AW + 1)'(DEPTH));
  assign level_o = level_q;
  // Head is forced to zero while empty so outputs read 0 after reset.
  assign rdata_o = valid_o ? mem_q[rptr_q] : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= wdata_i;
        wptr_q        <= wptr_q + 1'b1;
      end
      if (do_pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
      if (do_push && !do_pop) begin
        level_q <= level_q + 1'b1;
      end else if (!do_push && do_pop) begin
        level_q <= level_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/kbd_event_decoder.sv
// PS/2 scan-code parser: prefix FSM, held-key bitmap and event FIFO.
// Define KBD_REPEAT_EVT_EN to emit typematic repeats as events instead of dropping them.
module kbd_event_decoder
  import kbd_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CNT_W      = 8,
  localparam int unsigned LW        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_ready,
  input  logic             rx_overflow,
  output logic             rx_nextdata_n,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [7:0]       evt_code,
  output logic             evt_ext,
  output logic             evt_break,
  output logic             evt_repeat,
  output logic [LW-1:0]    fifo_level,
  output logic [9:0]       held_count,
  output logic [CNT_W-1:0] press_count,
  output logic             ovf_sticky
);

  state_e           state_q, state_d;
  logic [2:0]       skip_q, skip_d;
  logic             nd_q;
  logic [511:0]     bitmap_q;
  logic [9:0]       held_q;
  logic [CNT_W-1:0] press_q;
  logic             ovf_q;

  logic             err_byte, is_make, is_break, pause_push, ext;
  logic             held_bit, new_press, repeat_push, want_push, accept, fifo_full;
  logic [8:0]       bit_idx;
  kbd_evt_t         evt_in, evt_head;

  assign err_byte  = (rx_data == 8'h00) || (rx_data == 8'hFF);
  assign fifo_full = (fifo_level == LW'(FIFO_DEPTH));

  // Byte classification for the current state.
  always_comb begin
    is_make    = 1'b0;
    is_break   = 1'b0;
    pause_push = 1'b0;
    ext        = 1'b0;
    if (!err_byte) begin
      unique case (state_q)
        StIdle: is_make = (rx_data != PFX_E0) && (rx_data != PFX_F0) && (rx_data != PFX_E1);
        StE0: begin
          is_make = (rx_data != PFX_F0);
          ext     = 1'b1;
        end
        StF0:   is_break = 1'b1;
        StE0F0: begin
          is_break = 1'b1;
          ext      = 1'b1;
        end
        StPause: pause_push = (skip_q == 3'd1);
        default: ;
      endcase
    end
  end

  assign bit_idx   = {ext, rx_data};
  assign held_bit  = bitmap_q[bit_idx];
  assign new_press = is_make & ~held_bit;
`ifdef KBD_REPEAT_EVT_EN
  assign repeat_push = is_make & held_bit;
`else
  assign repeat_push = 1'b0;
`endif
  assign want_push = pause_push | is_break | new_press | repeat_push;
  // Events wait for FIFO room; prefix and suppressed bytes never stall.
  assign accept    = rx_ready & nd_q & (~want_push | ~fifo_full);

  always_comb begin
    evt_in.rpt  = repeat_push;
    evt_in.brk  = is_break;
    evt_in.ext  = ext | pause_push;
    evt_in.code = pause_push ? PAUSE_CODE : rx_data;
  end

  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    if (accept) begin
      if (err_byte) begin
        state_d = StIdle;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (rx_data == PFX_E0) begin
              state_d = StE0;
            end else if (rx_data == PFX_F0) begin
              state_d = StF0;
            end else if (rx_data == PFX_E1) begin
              state_d = StPause;
              skip_d  = PAUSE_SKIP;
            end
          end
          StE0:   state_d = (rx_data == PFX_F0) ? StE0F0 : StIdle;
          StF0:   state_d = StIdle;
          StE0F0: state_d = StIdle;
          StPause: begin
            skip_d = skip_q - 3'd1;
            if (skip_q == 3'd1) state_d = StIdle;
          end
          default: state_d = StIdle;
        endcase
      end
      if (rx_overflow) state_d = StIdle;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      skip_q  <= '0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      nd_q     <= 1'b1;
      bitmap_q <= '0;
      held_q   <= '0;
      press_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      nd_q <= ~accept;
      if (accept) begin
        if (rx_overflow) ovf_q <= 1'b1;
        if (new_press) begin
          bitmap_q[bit_idx] <= 1'b1;
          held_q            <= held_q + 1'b1;
          press_q           <= press_q + 1'b1;
        end
        if (is_break) begin
          bitmap_q[bit_idx] <= 1'b0;
          if (held_bit) held_q <= held_q - 1'b1;
        end
      end
    end
  end

  kbd_evt_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (accept & want_push),
    .wdata_i (evt_in),
    .ready_i (evt_ready),
    .valid_o (evt_valid),
    .rdata_o (evt_head),
    .level_o (fifo_level)
  );

  assign rx_nextdata_n = nd_q;
  assign evt_code      = evt_head.code;
  assign evt_ext       = evt_head.ext;
  assign evt_break     = evt_head.brk;
  assign held_count    = held_q;
  assign press_count   = press_q;
  assign ovf_sticky    = ovf_q;
`ifdef KBD_REPEAT_EVT_EN
  assign evt_repeat = evt_head.rpt;
`else
  logic unused_rpt;
  assign unused_rpt = evt_head.rpt;
  assign evt_repeat = 1'b0;
`endif

endmodule

// File: tb/tb_kbd_event_decoder.sv
// Directed bench for kbd_event_decoder with a byte-queue model of the PS/2 receiver.
module tb_kbd_event_decoder;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_ready = 1'b0;
  logic          rx_overflow = 1'b0;
  logic          rx_nextdata_n;
  logic          evt_valid;
  logic          evt_ready = 1'b0;
  logic [7:0]    evt_code;
  logic          evt_ext, evt_break, evt_repeat;
  logic [2:0]    fifo_level;
  logic [9:0]    held_count;
  logic [CW-1:0] press_count;
  logic          ovf_sticky;

  kbd_event_decoder #(
    .FIFO_DEPTH (DEPTH),
    .CNT_W      (CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_data       (rx_data),
    .rx_ready      (rx_ready),
    .rx_overflow   (rx_overflow),
    .rx_nextdata_n (rx_nextdata_n),
    .evt_valid     (evt_valid),
    .evt_ready     (evt_ready),
    .evt_code      (evt_code),
    .evt_ext       (evt_ext),
    .evt_break     (evt_break),
    .evt_repeat    (evt_repeat),
    .fifo_level    (fifo_level),
    .held_count    (held_count),
    .press_count   (press_count),
    .ovf_sticky    (ovf_sticky)
  );

  always #5 clk = ~clk;

  logic [7:0]  rxq [$];
  logic [10:0] got [$];
  int n_chk = 0, n_pass = 0, n_fail = 0;
  int acks = 0, long_low = 0;
  logic low_prev = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_rx();
    rx_ready = (rxq.size() > 0);
    rx_data  = (rxq.size() > 0) ? rxq[0] : 8'h00;
  endtask

  // One clock: sample strobe/pop before the edge, update receiver model after it.
  task automatic cyc();
    logic nd, take;
    logic [10:0] e;
    nd   = rx_nextdata_n;
    take = evt_valid & evt_ready;
    e    = {evt_repeat, evt_break, evt_ext, evt_code};
    if (!nd) begin
      acks++;
      if (low_prev) long_low++;
    end
    low_prev = !nd;
    @(posedge clk);
    #1;
    if (!nd && rxq.size() > 0) void'(rxq.pop_front());
    if (take) got.push_back(e);
    drive_rx();
  endtask

  task automatic send(input logic [7:0] b);
    rxq.push_back(b);
    drive_rx();
  endtask

  task automatic run_idle(input string tag);
    int n = 0;
    while ((rxq.size() != 0 || !rx_nextdata_n) && n < 300) begin
      cyc();
      n++;
    end
    chk({"idle_", tag}, 32'(n < 300), 32'd1);
    repeat (3) cyc();
  endtask

  task automatic chk_evt(input string tag, input logic [10:0] exp);
    logic [10:0] obs = 'x;
    if (got.size() > 0) obs = got.pop_front();
    chk(tag, 32'(obs), 32'(exp));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    evt_ready = 1'b0;
    rxq.delete();
    drive_rx();
    cyc();
    cyc();
    rst = 1'b0;
    evt_ready = 1'b1;
    got.delete();
  endtask

  initial begin
    #1;
    do_reset();
    chk("rst_nd", 32'(rx_nextdata_n), 32'd1);
    chk("rst_valid", 32'(evt_valid), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_held", 32'(held_count), 32'd0);
    chk("rst_press", 32'(press_count), 32'd0);
    chk("rst_ovf", 32'(ovf_sticky), 32'd0);
    chk("rst_code", 32'({evt_code, evt_ext, evt_break, evt_repeat}), 32'd0);

    // Press and release 1C.
    acks = 0;
    send(8'h1C);
    run_idle("t1a");
    chk("t1_held1", 32'(held_count), 32'd1);
    send(8'hF0); send(8'h1C);
    run_idle("t1b");
    chk("t1_held0", 32'(held_count), 32'd0);
    chk("t1_press", 32'(press_count), 32'd1);
    chk("t1_acks", 32'(acks), 32'd3);
    chk("t1_pulse1", 32'(long_low), 32'd0);
    chk("t1_nevt", 32'(got.size()), 32'd2);
    chk_evt("t1_make", 11'h01C);
    chk_evt("t1_break", 11'h21C);

    // Break of a key that is not held.
    send(8'hF0); send(8'h33);
    run_idle("t1c");
    chk_evt("t1_brk_nh", 11'h233);
    chk("t1_held_nh", 32'(held_count), 32'd0);

    // Extended make and break.
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
    run_idle("t2");
    chk("t2_nevt", 32'(got.size()), 32'd2);
    chk_evt("t2_make", 11'h175);
    chk_evt("t2_break", 11'h375);
    chk("t2_press", 32'(press_count), 32'd2);

    // Typematic repeats.
    repeat (4) send(8'h1C);
    send(8'hF0); send(8'h1C);
    run_idle("t3");
`ifdef KBD_REPEAT_EVT_EN
    chk("t3_nevt", 32'(got.size()), 32'd5);
    chk_evt("t3_make", 11'h01C);
    chk_evt("t3_rpt0", 11'h41C);
    chk_evt("t3_rpt1", 11'h41C);
    chk_evt("t3_rpt2", 11'h41C);
`else
    chk("t3_nevt", 32'(got.size()), 32'd2);
    chk_evt("t3_make", 11'h01C);
`endif
    chk_evt("t3_break", 11'h21C);
    chk("t3_press", 32'(press_count), 32'd3);
    chk("t3_held", 32'(held_count), 32'd0);

    // FIFO full back-pressure; press_count also wraps here (3 bits).
    evt_ready = 1'b0;
    send(8'h15); send(8'h1D); send(8'h24); send(8'h2D); send(8'h2C);
    repeat (40) cyc();
    chk("t4_level_full", 32'(fifo_level), 32'd4);
    chk("t4_stalled", 32'(rxq.size()), 32'd1);
    chk("t4_nd_high", 32'(rx_nextdata_n), 32'd1);
    chk("t4_press7", 32'(press_count), 32'd7);
    evt_ready = 1'b1;
    cyc();
    evt_ready = 1'b0;
    chk_evt("t4_pop0", 11'h015);
    repeat (10) cyc();
    chk("t4_level_refill", 32'(fifo_level), 32'd4);
    chk("t4_drained_rx", 32'(rxq.size()), 32'd0);
    chk("t4_press_wrap", 32'(press_count), 32'd0);
    evt_ready = 1'b1;
    repeat (8) cyc();
    chk_evt("t4_pop1", 11'h01D);
    chk_evt("t4_pop2", 11'h024);
    chk_evt("t4_pop3", 11'h02D);
    chk_evt("t4_pop4", 11'h02C);
    chk("t4_level_empty", 32'(fifo_level), 32'd0);
    chk("t4_held", 32'(held_count), 32'd5);

    // Pause sequence.
    do_reset();
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    run_idle("t5");
    chk("t5_nevt", 32'(got.size()), 32'd1);
    chk_evt("t5_pause", 11'h177);
    chk("t5_held", 32'(held_count), 32'd0);

    // Error byte after E0 returns to idle.
    send(8'hE0); send(8'h00); send(8'h75);
    run_idle("t6");
    chk("t6_nevt", 32'(got.size()), 32'd1);
    chk_evt("t6_make", 11'h075);

    // Overflow during F0 aborts the prefix.
    rx_overflow = 1'b1;
    send(8'hF0);
    run_idle("t7a");
    rx_overflow = 1'b0;
    send(8'h1C);
    run_idle("t7b");
    chk("t7_ovf", 32'(ovf_sticky), 32'd1);
    chk("t7_nevt", 32'(got.size()), 32'd1);
    chk_evt("t7_make", 11'h01C);
    chk("t7_held", 32'(held_count), 32'd2);

    // Reset while in E0F0.
    send(8'hE0); send(8'hF0);
    run_idle("t8a");
    rst = 1'b1;
    cyc();
    chk("t8_nd", 32'(rx_nextdata_n), 32'd1);
    chk("t8_zero", 32'({evt_valid, evt_code, evt_ext, evt_break, evt_repeat, fifo_level,
                        held_count, press_count, ovf_sticky}), 32'd0);
    rst = 1'b0;
    got.delete();
    send(8'h75);
    run_idle("t8b");
    chk("t8_nevt", 32'(got.size()), 32'd1);
    chk_evt("t8_make", 11'h075);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/kbd_event_decoder.md
Name: kbd_event_decoder

Overview:
- Parametrised successor to the single-key PS/2 keyboard controller.
- Consumes the byte stream from the ps2_keyboard receiver (data/ready/overflow/nextdata_n handshake).
- Parses E0/F0/E1 prefixes and tracks held keys in a 512-bit bitmap, so typematic repeats are suppressed.
- Pushes make/break events into a FWFT event FIFO with valid/ready output; downstream consumers are the display/ASCII stage.

Parameters:
FIFO_DEPTH, 8, event FIFO entries; power of two, >=2
CNT_W, 8, width of press_count (wraps)

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
rx_data  in  8  byte from ps2_keyboard
rx_ready  in  1  receiver holds an unread byte
rx_overflow  in  1  receiver overflow flag
rx_nextdata_n  out  1  active-low one-cycle read strobe to receiver
evt_valid  out  1  FIFO head valid
evt_ready  in  1  consumer takes head
evt_code  out  8  scan code
evt_ext  out  1  E0-prefixed code
evt_break  out  1  1 = release, 0 = press
evt_repeat  out  1  typematic repeat (see Optional Feature)
fifo_level  out  $clog2(FIFO_DEPTH)+1  occupied entries
held_count  out  10  number of set bitmap bits
press_count  out  CNT_W  new-press counter
ovf_sticky  out  1  receiver overflow seen since reset

Behaviour:
- Reset (rst=1 at posedge):
  - rx_nextdata_n=1; all other outputs 0.
  - FIFO empty, bitmap cleared, FSM=IDLE.
  - Reset mid-sequence discards any partial prefix state.
- Handshake with receiver:
  - Accept a byte when rx_ready=1, rx_nextdata_n=1 in the current cycle, and the push condition holds.
  - On accept: drive rx_nextdata_n=0 for exactly one cycle, then 1. This guarantees back-to-back accepts are at least 2 cycles apart.
- Push condition:
  - A byte that produces an event is accepted only if fifo_level < FIFO_DEPTH, measured before any same-cycle pop (no pop bypass).
  - Prefix bytes and suppressed bytes are always accepted.
- FSM states: IDLE, E0, F0, E0F0, PAUSE.
  - IDLE: E0 -> E0; F0 -> F0; E1 -> PAUSE (skip counter=7); any other byte is a make with ext=0.
  - E0: F0 -> E0F0; other byte is a make with ext=1, then -> IDLE.
  - F0: byte is a break with ext=0 -> IDLE. E0F0: byte is a break with ext=1 -> IDLE.
  - PAUSE: consume 7 bytes. On the last byte, push make {code=77, ext=1}, not tracked in the bitmap -> IDLE.
- Error bytes 00 and FF: consumed, no event, FSM -> IDLE.
- Make handling:
  - Bitmap bit {ext,code} clear: set it, push event, held_count+1, press_count+1.
  - Bit already set: typematic repeat; suppressed (default).
- Break handling:
  - Always push the event and clear the bit.
  - held_count-1 only if the bit was set; a break of a non-held key leaves the bitmap unchanged.
- rx_overflow=1 while a byte is accepted: ovf_sticky<=1, FSM forced to IDLE after processing. ovf_sticky clears only on rst.
- FIFO latency:
  - A push at the posedge ending cycle N makes evt_valid=1 in cycle N+1.
  - Pop on evt_valid & evt_ready.
  - Simultaneous push and pop leaves fifo_level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- press_count wraps from 2^CNT_W-1 to 0.

Optional Feature:
- Macro KBD_REPEAT_EVT_EN.
- Defined: typematic repeats push an event with evt_repeat=1, evt_break=0. They are subject to the FIFO push condition, and press_count/held_count are unchanged.
- Undefined: repeats are dropped and evt_repeat is tied 0.

Decomposition:
- Package kbd_pkg holds:
  - prefix constants PFX_E0=8'hE0, PFX_F0=8'hF0, PFX_E1=8'hE1, PAUSE_CODE=8'h77
  - FSM state enum
  - packed event struct {repeat, brk, ext, code[7:0]}, 11 bits
- One sub-module: kbd_evt_fifo, a FWFT FIFO of the event struct with level output.

Test Plan:
- Bytes 1C, F0, 1C -> events {1C,make}, {1C,break}; press_count=1; held_count 1 then 0; rx_nextdata_n pulses 3 times, each 1 cycle.
- E0 75, then E0 F0 75 -> {75,ext=1,make} and {75,ext=1,break}; prefixes produce no events.
- 1C repeated 4 times, then F0 1C -> default build gives 2 events with press_count=1; with KBD_REPEAT_EVT_EN, 5 events, 3 of them evt_repeat=1.
- FIFO_DEPTH=4, evt_ready=0, 5 distinct makes -> fifo_level=4; 5th byte not acked (rx_nextdata_n stays 1); one pop -> 5th accepted, level returns to 4.
- E1 14 77 E1 F0 14 F0 77 -> single event {77,ext=1,make}; held_count=0.
- rx_overflow=1 with byte F0, then 1C -> ovf_sticky=1; 1C is reported as a make, not a break. Assert rst mid E0F0 -> all outputs 0 the next cycle.
